// File: rtl/qam_mapper.sv
// qam_mapper: collects Nbpsc serial interleaved bits per subcarrier and maps each group to a
// Gray-coded, normalised Q1.6 BPSK/QPSK/16-QAM/64-QAM point for the IFFT input buffer.
module qam_mapper #(
  parameter int Nbpsc = 1,
  parameter int Nsd   = 48
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              EN,
  input  logic              Data,
  input  logic              In_valid,
  output logic signed [7:0] I_out,
  output logic signed [7:0] Q_out,
  output logic              Out_valid,
  output logic [5:0]        Sc_index,
  output logic              Sym_done
);
  localparam bit         LEGAL    = (Nbpsc == 1) || (Nbpsc == 2) || (Nbpsc == 4) || (Nbpsc == 6);
  localparam logic [2:0] LAST_BIT = 3'(Nbpsc - 1);
  localparam logic [5:0] LAST_SC  = 6'(Nsd - 1);

  function automatic logic signed [7:0] apply_sign(input logic pos, input logic signed [7:0] mag);
    return pos ? mag : -mag;
  endfunction

  // 16-QAM axis: first bit is the sign, second selects inner (1) vs outer (3) level
  function automatic logic signed [7:0] map16(input logic b_hi, input logic b_lo);
    return apply_sign(b_hi, b_lo ? 8'sd20 : 8'sd61);
  endfunction

  // 64-QAM axis: first bit is the sign, remaining two Gray-select 7/5/3/1
  function automatic logic signed [7:0] map64(input logic b_hi, input logic b_mid, input logic b_lo);
    logic signed [7:0] mag;
    case ({b_mid, b_lo})
      2'b00:   mag = 8'sd69;
      2'b01:   mag = 8'sd49;
      2'b11:   mag = 8'sd30;
      default: mag = 8'sd10;
    endcase
    return apply_sign(b_hi, mag);
  endfunction

  logic [5:0]        bits_reg, bits_next, group;
  logic [2:0]        bitcnt_reg, bitcnt_next;
  logic [5:0]        sc_cnt_reg, sc_cnt_next;
  logic [5:0]        sc_index_reg, sc_index_next;
  logic signed [7:0] i_reg, i_next, q_reg, q_next, i_map, q_map;
  logic              valid_reg, valid_next;
  logic              sym_done_reg, sym_done_next;

  // Group as it will be once the bit arriving this cycle is stored
  always_comb begin
    group             = bits_reg;
    group[bitcnt_reg] = Data;
    i_map             = '0;
    q_map             = '0;
    case (Nbpsc)
      1: i_map = apply_sign(group[0], 8'sd64);
      2: begin
        i_map = apply_sign(group[0], 8'sd45);
        q_map = apply_sign(group[1], 8'sd45);
      end
      4: begin
        i_map = map16(group[0], group[1]);
        q_map = map16(group[2], group[3]);
      end
      6: begin
        i_map = map64(group[0], group[1], group[2]);
        q_map = map64(group[3], group[4], group[5]);
      end
      default: ;
    endcase
  end

  always_comb begin
    bits_next     = bits_reg;
    bitcnt_next   = bitcnt_reg;
    sc_cnt_next   = sc_cnt_reg;
    sc_index_next = sc_index_reg;
    i_next        = i_reg;
    q_next        = q_reg;
    valid_next    = 1'b0;
    sym_done_next = 1'b0;
    if (!EN) begin
      bits_next     = '0;
      bitcnt_next   = '0;
      sc_cnt_next   = '0;
      sc_index_next = '0;
      i_next        = '0;
      q_next        = '0;
    end else if (In_valid) begin
      if (bitcnt_reg == LAST_BIT) begin
        bits_next   = '0;
        bitcnt_next = '0;
        if (LEGAL) begin
          valid_next    = 1'b1;
          i_next        = i_map;
          q_next        = q_map;
          sc_index_next = sc_cnt_reg;
          sym_done_next = (sc_cnt_reg == LAST_SC);
          sc_cnt_next   = (sc_cnt_reg == LAST_SC) ? 6'd0 : sc_cnt_reg + 6'd1;
        end
      end else begin
        bits_next   = group;
        bitcnt_next = bitcnt_reg + 3'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bits_reg     <= '0;
      bitcnt_reg   <= '0;
      sc_cnt_reg   <= '0;
      sc_index_reg <= '0;
      i_reg        <= '0;
      q_reg        <= '0;
      valid_reg    <= 1'b0;
      sym_done_reg <= 1'b0;
    end else begin
      bits_reg     <= bits_next;
      bitcnt_reg   <= bitcnt_next;
      sc_cnt_reg   <= sc_cnt_next;
      sc_index_reg <= sc_index_next;
      i_reg        <= i_next;
      q_reg        <= q_next;
      valid_reg    <= valid_next;
      sym_done_reg <= sym_done_next;
    end
  end

  assign I_out     = i_reg;
  assign Q_out     = q_reg;
  assign Out_valid = valid_reg;
  assign Sc_index  = sc_index_reg;
  assign Sym_done  = sym_done_reg;
endmodule

// File: tb/tb_qam_mapper.sv
// Testbench for qam_mapper: one instance per Nbpsc (1,2,4,6) plus an illegal Nbpsc=3 instance,
// checked against a constellation model derived from Gray decoding and average-energy scaling.
module tb_qam_mapper;
  localparam int NINST = 5;
  localparam int NB_TAB [NINST] = '{1, 2, 4, 6, 3};

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic en = 1'b0;
  logic data = 1'b0;
  logic in_valid = 1'b0;
  logic signed [7:0] i_out [NINST];
  logic signed [7:0] q_out [NINST];
  logic              out_valid [NINST];
  logic [5:0]        sc_index [NINST];
  logic              sym_done [NINST];

  int n_checks = 0;
  int n_fail = 0;
  int illegal_strobes = 0;

  typedef struct {
    logic              v;
    logic signed [7:0] i;
    logic signed [7:0] q;
    logic [5:0]        sc;
    logic              sd;
  } obs_t;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NINST; gi++) begin : g_dut
      qam_mapper #(.Nbpsc(NB_TAB[gi]), .Nsd(48)) u_dut (
        .Clk(clk), .Reset(reset_n), .EN(en), .Data(data), .In_valid(in_valid),
        .I_out(i_out[gi]), .Q_out(q_out[gi]), .Out_valid(out_valid[gi]),
        .Sc_index(sc_index[gi]), .Sym_done(sym_done[gi])
      );
    end
  endgenerate

  always @(posedge clk) if (out_valid[4] === 1'b1) illegal_strobes <= illegal_strobes + 1;

  // Level from Gray bits: decode to a binary index, centre it, scale to unit average energy
  function automatic int axis_value(input bit b[$], input int first, input int k, input real energy);
    int idx = 0;
    bit g = 1'b0;
    int level, mag;
    for (int j = 0; j < k; j++) begin
      g   = g ^ b[first + j];
      idx = idx * 2 + int'(g);
    end
    level = 2 * idx - ((1 << k) - 1);
    mag   = $rtoi(real'(level < 0 ? -level : level) * 64.0 / $sqrt(energy) + 0.5);
    return (level < 0) ? -mag : mag;
  endfunction

  function automatic void ref_point(input int n, input bit b[$], output int ei, output int eq);
    int k;
    real m, energy;
    k      = (n == 1) ? 1 : n / 2;
    m      = real'(1 << k);
    energy = (n == 1) ? 1.0 : 2.0 * (m * m - 1.0) / 3.0;
    ei     = axis_value(b, 0, k, energy);
    eq     = (n == 1) ? 0 : axis_value(b, k, k, energy);
  endfunction

  task automatic cycle(input logic e, input logic iv, input logic d, input int k, output obs_t o);
    en = e; in_valid = iv; data = d;
    @(posedge clk);
    #1;
    o.v = out_valid[k]; o.i = i_out[k]; o.q = q_out[k]; o.sc = sc_index[k]; o.sd = sym_done[k];
  endtask

  task automatic clear();
    obs_t o;
    cycle(1'b0, 1'b0, 1'b0, 0, o);
  endtask

  task automatic test_reset();
    obs_t o;
    reset_n = 1'b0; en = 1'b0; in_valid = 1'b0; data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NINST; k++) begin
      n_checks++;
      if ({out_valid[k], i_out[k], q_out[k], sc_index[k], sym_done[k]} !== 24'd0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got v=%b I=%0d Q=%0d sc=%0d sd=%b required all 0",
                 k, out_valid[k], i_out[k], q_out[k], sc_index[k], sym_done[k]);
      end
    end
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 1'b1, 1'b1, 0, o);
      for (int k = 0; k < NINST; k++) begin
        n_checks++;
        if (out_valid[k] !== 1'b0 || i_out[k] !== 8'sd0) begin
          n_fail++;
          $display("FAIL en_low_idle[%0d]: got v=%b I=%0d required v=0 I=0", k, out_valid[k], i_out[k]);
        end
      end
    end
    $display("reset: outputs cleared, EN low keeps Out_valid low");
  endtask

  task automatic test_bpsk();
    obs_t o;
    logic d [3] = '{1'b1, 1'b0, 1'b1};
    int   ei [3] = '{64, -64, 64};
    clear();
    for (int j = 0; j < 3; j++) begin
      cycle(1'b1, 1'b1, d[j], 0, o);
      n_checks++;
      if (o.v !== 1'b1 || o.i !== 8'(ei[j]) || o.q !== 8'sd0 || o.sc !== 6'(j) || o.sd !== 1'b0) begin
        n_fail++;
        $display("FAIL bpsk[%0d]: got v=%b I=%0d Q=%0d sc=%0d sd=%b required v=1 I=%0d Q=0 sc=%0d sd=0",
                 j, o.v, o.i, o.q, o.sc, o.sd, ei[j], j);
      end
      $display("bpsk point sc=%0d I=%0d Q=%0d", o.sc, o.i, o.q);
    end
  endtask

  task automatic test_qam16_gap();
    obs_t o;
    logic iv [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic d  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    clear();
    for (int j = 0; j < 6; j++) begin
      cycle(1'b1, iv[j], d[j], 2, o);
      n_checks++;
      if (o.v !== (j == 5)) begin
        n_fail++;
        $display("FAIL qam16_strobe[%0d]: got %b required %b", j, o.v, (j == 5));
      end
    end
    n_checks++;
    if (o.i !== 8'sd61 || o.q !== -8'sd20 || o.sc !== 6'd0) begin
      n_fail++;
      $display("FAIL qam16_point: got I=%0d Q=%0d sc=%0d required I=61 Q=-20 sc=0", o.i, o.q, o.sc);
    end
    $display("qam16 point sc=%0d I=%0d Q=%0d", o.sc, o.i, o.q);
    cycle(1'b1, 1'b0, 1'b0, 2, o);
    n_checks++;
    if (o.v !== 1'b0 || o.i !== 8'sd61 || o.q !== -8'sd20) begin
      n_fail++;
      $display("FAIL qam16_hold: got v=%b I=%0d Q=%0d required v=0 I=61 Q=-20", o.v, o.i, o.q);
    end
  endtask

  task automatic test_qam64_symbol();
    obs_t o;
    clear();
    for (int p = 0; p < 49; p++) begin
      for (int b = 0; b < 6; b++) begin
        cycle(1'b1, 1'b1, 1'b1, 3, o);
        n_checks++;
        if (o.v !== (b == 5)) begin
          n_fail++;
          $display("FAIL qam64_strobe[p%0d b%0d]: got %b required %b", p, b, o.v, (b == 5));
        end
      end
      n_checks++;
      if (o.i !== 8'sd30 || o.q !== 8'sd30 || o.sc !== 6'(p % 48) || o.sd !== (p % 48 == 47)) begin
        n_fail++;
        $display("FAIL qam64_point[%0d]: got I=%0d Q=%0d sc=%0d sd=%b required I=30 Q=30 sc=%0d sd=%b",
                 p, o.i, o.q, o.sc, o.sd, p % 48, (p % 48 == 47));
      end
      $display("qam64 point sc=%0d I=%0d Q=%0d sd=%b", o.sc, o.i, o.q, o.sd);
    end
  endtask

  task automatic test_en_abort();
    obs_t o;
    clear();
    cycle(1'b1, 1'b1, 1'b1, 1, o);
    cycle(1'b1, 1'b1, 1'b1, 1, o);
    n_checks++;
    if (o.v !== 1'b1 || o.sc !== 6'd0) begin
      n_fail++;
      $display("FAIL abort_first: got v=%b sc=%0d required v=1 sc=0", o.v, o.sc);
    end
    cycle(1'b1, 1'b1, 1'b1, 1, o);
    cycle(1'b0, 1'b1, 1'b1, 1, o);
    cycle(1'b1, 1'b1, 1'b0, 1, o);
    n_checks++;
    if (o.v !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_partial: got v=%b required 0", o.v);
    end
    cycle(1'b1, 1'b1, 1'b1, 1, o);
    n_checks++;
    if (o.v !== 1'b1 || o.i !== -8'sd45 || o.q !== 8'sd45 || o.sc !== 6'd0) begin
      n_fail++;
      $display("FAIL abort_point: got v=%b I=%0d Q=%0d sc=%0d required v=1 I=-45 Q=45 sc=0",
               o.v, o.i, o.q, o.sc);
    end
    $display("qpsk point after abort sc=%0d I=%0d Q=%0d", o.sc, o.i, o.q);
  endtask

  task automatic test_async_reset();
    obs_t o;
    bit   q[$];
    int   ei, eq;
    clear();
    for (int p = 0; p < 7; p++) begin
      q.delete();
      for (int b = 0; b < 6; b++) begin
        bit d = 1'($urandom_range(0, 1));
        q.push_back(d);
        cycle(1'b1, 1'b1, d, 3, o);
      end
      ref_point(6, q, ei, eq);
      n_checks++;
      if (o.v !== 1'b1 || o.i !== 8'(ei) || o.q !== 8'(eq) || o.sc !== 6'(p == 6 ? 0 : p)) begin
        n_fail++;
        $display("FAIL rst_point[%0d]: got v=%b I=%0d Q=%0d sc=%0d required v=1 I=%0d Q=%0d sc=%0d",
                 p, o.v, o.i, o.q, o.sc, ei, eq, (p == 6 ? 0 : p));
      end
      $display("qam64 point sc=%0d I=%0d Q=%0d", o.sc, o.i, o.q);
      if (p == 5) begin
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid[3], i_out[3], q_out[3], sc_index[3], sym_done[3]} !== 24'd0) begin
          n_fail++;
          $display("FAIL async_reset: got v=%b I=%0d Q=%0d sc=%0d required all 0",
                   out_valid[3], i_out[3], q_out[3], sc_index[3]);
        end
        #1;
        reset_n = 1'b1;
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit   q[$];
    int   n, ei, eq, sc, exp_sc, li, lq;
    bit   e, iv, d, exp_v;
    for (int k = 0; k < 4; k++) begin
      n = NB_TAB[k];
      clear();
      q.delete(); sc = 0; li = 0; lq = 0; exp_sc = 0;
      for (int c = 0; c < 300; c++) begin
        e  = ($urandom_range(0, 19) != 0);
        iv = ($urandom_range(0, 3) != 0);
        d  = 1'($urandom_range(0, 1));
        exp_v = 1'b0;
        if (!e) begin
          q.delete(); sc = 0; li = 0; lq = 0;
        end else if (iv) begin
          q.push_back(d);
          if (q.size() == n) begin
            ref_point(n, q, ei, eq);
            exp_v = 1'b1; exp_sc = sc; sc = (sc + 1) % 48;
            li = ei; lq = eq;
            q.delete();
          end
        end
        cycle(e, iv, d, k, o);
        n_checks++;
        if (o.v !== exp_v || o.i !== 8'(li) || o.q !== 8'(lq)) begin
          n_fail++;
          $display("FAIL random_n%0d[%0d]: got v=%b I=%0d Q=%0d required v=%b I=%0d Q=%0d",
                   n, c, o.v, o.i, o.q, exp_v, li, lq);
        end
        if (exp_v) begin
          n_checks++;
          if (o.sc !== 6'(exp_sc) || o.sd !== (exp_sc == 47)) begin
            n_fail++;
            $display("FAIL random_idx_n%0d[%0d]: got sc=%0d sd=%b required sc=%0d sd=%b",
                     n, c, o.sc, o.sd, exp_sc, (exp_sc == 47));
          end
          $display("random n=%0d point sc=%0d I=%0d Q=%0d", n, o.sc, o.i, o.q);
        end
      end
    end
  endtask

  task automatic test_illegal();
    n_checks++;
    if (illegal_strobes != 0 || i_out[4] !== 8'sd0 || q_out[4] !== 8'sd0) begin
      n_fail++;
      $display("FAIL illegal_nbpsc: got strobes=%0d I=%0d Q=%0d required 0 0 0",
               illegal_strobes, i_out[4], q_out[4]);
    end
    $display("illegal Nbpsc=3: strobes=%0d", illegal_strobes);
  endtask

  initial begin
    test_reset();
    test_bpsk();
    test_qam16_gap();
    test_qam64_symbol();
    test_en_abort();
    test_async_reset();
    test_random();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/qam_mapper.md
Name: qam_mapper

Overview:
- Stage directly downstream of the interleaver.
- Consumes the interleaver's serial bit stream, one bit per Clk, and groups every Nbpsc bits into one subcarrier point.
- Maps each group to a Gray-coded, normalised BPSK/QPSK/16-QAM/64-QAM constellation point. Outputs are signed fixed-point I/Q samples with a valid strobe, a subcarrier index and an end-of-symbol pulse, for the IFFT input buffer.

Parameters:
- Nbpsc, default 1: coded bits per subcarrier. Legal values are 1, 2, 4, 6; any other value ties I_out/Q_out to 0 and never asserts Out_valid.
- Nsd, default 48: data subcarriers per OFDM symbol; Sc_index wraps at Nsd-1.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- EN  input  1  block enable; low = synchronous clear of collector and counters.
- Data  input  1  serial interleaved bit.
- In_valid  input  1  Data is sampled only when high.
- I_out  output  8  signed Q1.6 in-phase sample.
- Q_out  output  8  signed Q1.6 quadrature sample.
- Out_valid  output  1  one-cycle strobe per mapped point.
- Sc_index  output  6  subcarrier index of the current point, 0..Nsd-1.
- Sym_done  output  1  high together with Out_valid on point Nsd-1.

Behaviour:
- Reset low, asynchronously: I_out=0, Q_out=0, Out_valid=0, Sc_index=0, Sym_done=0, bit counter=0, shift register=0.
- EN low at a rising Clk: same clear as reset, performed synchronously. Input is ignored while EN is low.
- Collection:
  - On each Clk with EN and In_valid high, Data is stored as bit b[bitcnt] and bitcnt increments.
  - The first bit received is b0.
  - Cycles with In_valid low hold all state; gaps are legal at any bit position.
- Emission:
  - On the Clk that samples bit Nbpsc-1, bitcnt returns to 0 and the point is mapped.
  - At that same edge I_out/Q_out are registered and Out_valid=1.
  - Latency is therefore 1 cycle from the last bit's sampling edge to output visible.
- Out_valid is high for exactly one cycle per point. I_out/Q_out hold their last value otherwise.
- Sc_index:
  - Shows the index of the point being presented while Out_valid=1.
  - Increments after each emitted point and wraps Nsd-1 -> 0.
  - Sym_done=1 only in the cycle Out_valid=1 and Sc_index=Nsd-1.
- Back-to-back: with Nbpsc=1 and continuous In_valid, Out_valid is high every cycle. No stall or backpressure exists; the consumer must accept every strobe.
- Mapping (levels before normalisation, per 802.11a Gray code):
  - BPSK: b0 0->-1, 1->+1 on I; Q=0.
  - QPSK: b0->I, b1->Q, 0->-1, 1->+1.
  - 16QAM: (b0b1)->I, (b2b3)->Q; 00->-3, 01->-1, 11->+1, 10->+3.
  - 64QAM: (b0b1b2)->I, (b3b4b5)->Q; 000->-7, 001->-5, 011->-3, 010->-1, 110->+1, 111->+3, 101->+5, 100->+7.
- Normalised Q1.6 magnitudes (64 = 1.0), in two's complement, with negatives as exact negation:
  - BPSK: 64.
  - QPSK: 45.
  - 16QAM: 1->20, 3->61.
  - 64QAM: 1->10, 3->30, 5->49, 7->69.
- Mid-group disturbances:
  - EN deassert or reset mid-group discards the partial bits. The next group starts at b0 with Sc_index=0.
  - Reset asserted during an Out_valid cycle forces Out_valid=0 immediately.

Test Plan:
- Reset low for 3 cycles, then release with EN=0 -> all outputs 0; Out_valid never asserts.
- Nbpsc=1, EN=1, In_valid continuous, Data=1,0,1 -> Out_valid every cycle; I_out=64, -64 (0xC0), 64; Q_out=0; Sc_index=0,1,2.
- Nbpsc=4, bits 1,0,0,1 with an In_valid gap of 2 cycles after bit 1 -> single Out_valid one cycle after the 4th bit; I_out=61, Q_out=-20 (0xEC).
- Nbpsc=6, 48 groups of all-ones continuous -> 48 strobes each 6 cycles apart; I_out=Q_out=30; Sym_done only on Sc_index=47; next point Sc_index=0.
- Nbpsc=2, deassert EN after bit b0 then resume with bits 0,1 -> discarded partial; one point I=-45 (0xD3), Q=45, Sc_index=0.
- Nbpsc=6, assert Reset in the Out_valid cycle of point 5 -> outputs 0 asynchronously; after release the first new point reports Sc_index=0.
